instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Sequential RV32I instruction encoder: the inverse of the team's combinational instruction decoder.
- Accepts a decoded field bundle (format class, funct3/funct7, register indices, full 32-bit immediate) over a valid/ready handshake and packs it into a 32-bit instruction word.
- Encoded words are queued in a small output FIFO with its own valid/ready handshake.
- Used by the program loader, the self-test instruction generator and decoder round-trip benches.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept this cycle.
- in_fmt  input  3  class: 0 R, 1 I_ALU, 2 LOAD, 3 S, 4 B, 5 JAL, 6 JALR, 7 LUI.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field (R; I_ALU shifts).
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_imm  input  32  byte-valued immediate (LUI: full upper value, not pre-shifted).
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_instr  output  32  encoded word at FIFO head; 0 when out_valid=0.
- out_err  output  1  head entry had immediate range/alignment violation.

Behaviour:
- Reset: FIFO count, read pointer and write pointer = 0; out_valid=0, out_instr=0, out_err=0, in_ready=1. Reset takes effect immediately, mid-transfer included; queued entries are discarded.
- Accept: in_valid & in_ready at a rising edge. The word is encoded combinationally and written to the FIFO at that edge.
- Latency: out_valid rises the cycle after accept when the FIFO was empty. There is no combinational in-to-out path.
- in_ready = (count != DEPTH), derived from registered count only; it never depends on out_ready.
- Pop: out_valid & out_ready. Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged. When full, push is blocked and pop alone proceeds. When empty, no pop occurs.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- Opcodes: R 0110011, I_ALU 0010011, LOAD 0000011, S 0100011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
- Fields: rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- Field suppression: fields unused by a class are forced to 0 (e.g. rd for S/B, rs1 for JAL/LUI). JALR funct3 is forced to 000.
- I_ALU shifts (funct3 001/101): [31:25]=funct7, [24:20]=imm[4:0].
- Other I_ALU, LOAD and JALR: [31:20]=imm[11:0].
- S: [31:25]=imm[11:5], [11:7]=imm[4:0].
- B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- JAL: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- LUI: [31:12]=imm[31:12].
- Out-of-range immediates are truncated per the field map above; the word is still emitted.

Optional Feature:
- Macro: INSTR_ENCODER_CHECK_EN.
- Defined: err bit is computed at accept and stored per FIFO entry. It is set when:
  - I_ALU, LOAD, JALR or S immediate is outside [-2048, 2047];
  - a shift immediate is outside [0, 31];
  - B immediate is outside [-4096, 4094] or odd;
  - JAL immediate is outside [-2^20, 2^20-2] or odd;
  - LUI imm[11:0] != 0.
- Undefined: no err storage; out_err tied 0.

Decomposition:
- Package instr_pkg holds the fmt enum (R..LUI), the 7-bit opcode constants and the immediate-limit localparams. The team's decoder imports the same package.
- One sub-module: instr_fifo, a generic DEPTH x WIDTH synchronous FIFO with count, full and empty. The encoder instantiates it with WIDTH=33 (word + err).

Test Plan:
- R add x3,x1,x2 (fmt0, f3=0, f7=0) -> out_instr=0x002081B3 one cycle later, out_err=0.
- I_ALU addi x1,x0,-1 (imm=0xFFFFFFFF) -> 0xFFF00093. S sw x2,8(x1) -> 0x0020A423.
- JAL x1,+8 -> 0x008000EF. LUI x5, imm=0x12345000 -> 0x123452B7. LUI imm=0x12345001 with INSTR_ENCODER_CHECK_EN -> same word, out_err=1. B imm=3 -> out_err=1.
- Backpressure at DEPTH=2: out_ready=0, push 3 bundles -> in_ready=0 after the 2nd and the 3rd is held. Raise out_ready -> words emerge in push order with no loss or duplication. Push and pop in the same cycle keep count steady.
- Assert rst_n=0 with 2 entries queued -> out_valid=0, out_instr=0 and in_ready=1 immediately. After release, the first new push appears alone.
- Random round-trip: drive random legal bundles, feed out_instr to the team decoder, compare the decoded rd/rs1/rs2/imm against the inputs over 10k transactions.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared RV32I encoding definitions: format classes, major opcodes and
// immediate range limits. The decoder imports this same package.
package instr_pkg;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I_ALU = 3'd1,
    FMT_LOAD  = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_JAL   = 3'd5,
    FMT_JALR  = 3'd6,
    FMT_LUI   = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_ALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;
  localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
  localparam logic signed [31:0] IMMJ_MAX  = 32'sd1048574;

  // Shift-immediate forms of OP-IMM (SLLI / SRLI / SRAI).
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

  // True when the immediate cannot be represented exactly by the class's field map.
  function automatic logic imm_violation(input fmt_e fmt, input logic [2:0] funct3,
                                         input logic [31:0] imm);
    logic signed [31:0] simm;
    logic               viol;
    simm = $signed(imm);
    viol = 1'b0;
    case (fmt)
      FMT_I_ALU: begin
        if (is_shift(funct3)) begin
          viol = (imm[31:5] != 27'd0);
        end else begin
          viol = (simm < IMM12_MIN) || (simm > IMM12_MAX);
        end
      end
      FMT_LOAD, FMT_JALR, FMT_S: viol = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      FMT_B:   viol = (simm < IMMB_MIN) || (simm > IMMB_MAX) || imm[0];
      FMT_JAL: viol = (simm < IMMJ_MIN) || (simm > IMMJ_MAX) || imm[0];
      FMT_LUI: viol = (imm[11:0] != 12'd0);
      default: viol = 1'b0;
    endcase
    return viol;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy count.
// Push is ignored when full, pop is ignored when empty; rdata reads 0 when empty.
module instr_fifo
  import instr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage, wrapping pointers and occupancy; reset discards all queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a decoded field bundle into a 32-bit word
// and queues it in an output FIFO. Optional macro INSTR_ENCODER_CHECK_EN adds a
// per-entry flag for immediates that the field map cannot represent exactly.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);

  localparam int CNT_W = PTR_W + 1;
`ifdef INSTR_ENCODER_CHECK_EN
  localparam int FIFO_W = 33;
`else
  localparam int FIFO_W = 32;
`endif

  fmt_e              fmt_s;
  logic [31:0]       word_s;
  logic [FIFO_W-1:0] wdata_s;
  logic [FIFO_W-1:0] rdata_s;
  logic [CNT_W-1:0]  count_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  assign fmt_s = fmt_e'(in_fmt);

  // Field packing per format class; fields a class does not use stay zero.
  always_comb begin
    word_s = 32'd0;
    case (fmt_s)
      FMT_R: word_s = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      FMT_I_ALU: begin
        if (is_shift(in_funct3)) begin
          word_s = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_I_ALU};
        end else begin
          word_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I_ALU};
        end
      end
      FMT_LOAD: word_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      FMT_S:    word_s = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
      FMT_B:    word_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], OP_B};
      FMT_JAL:  word_s = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      FMT_JALR: word_s = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      FMT_LUI:  word_s = {in_imm[31:12], in_rd, OP_LUI};
      default:  word_s = 32'd0;
    endcase
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic err_s;

  // Immediate range/alignment verdict, stored with the word at accept.
  always_comb begin
    err_s = imm_violation(fmt_s, in_funct3, in_imm);
  end

  assign wdata_s = {err_s, word_s};
  assign out_err = rdata_s[32];
`else
  assign wdata_s = word_s;
  assign out_err = 1'b0;
`endif

  // Acceptance depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_s != CNT_W'(DEPTH));
  assign push_s    = in_valid & ~full_s;
  assign pop_s     = out_valid & out_ready;
  assign out_valid = ~empty_s;
  assign out_instr = rdata_s[31:0];

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors with literal words,
// a queue scoreboard fed by an arithmetic encoding model, and an opcode-driven
// decoder that checks random legal bundles round-trip back to their fields.
module tb_instr_encoder;

  localparam int DEPTH = 2;
`ifdef INSTR_ENCODER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0]  fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic        out_err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  bundle_t     cur;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  bundle_t sb[$];
  bundle_t hd;
  bit      pushing;

  bundle_t     vb[13];
  logic [31:0] vw[13];
  bit          vi[13];

  assign in_fmt    = cur.fmt;
  assign in_funct3 = cur.f3;
  assign in_funct7 = cur.f7;
  assign in_rd     = cur.rd;
  assign in_rs1    = cur.rs1;
  assign in_rs2    = cur.rs2;
  assign in_imm    = cur.imm;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned bits(input longint unsigned x, input int hi, input int lo);
    return (x >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1);
  endfunction

  // Encoding model: each class fills the six standard slots (or the U/J upper
  // slot) with arithmetic, then the slots are weighted by their bit positions.
  function automatic logic [31:0] model_word(input bundle_t b);
    longint unsigned im, op, rd, f3, rs1, rs2, top7, up20, w;
    bit upper;
    im = 64'(b.imm); rd = 64'(b.rd); f3 = 64'(b.f3); rs1 = 64'(b.rs1);
    rs2 = 64'(b.rs2); top7 = 64'(b.f7); up20 = 64'd0; upper = 1'b0;
    case (b.fmt)
      3'd0: op = 64'd51;
      3'd1: begin
        op = 64'd19;
        rs2 = bits(im, 4, 0);
        if (!(b.f3 == 3'd1 || b.f3 == 3'd5)) top7 = bits(im, 11, 5);
      end
      3'd2: begin op = 64'd3; rs2 = bits(im, 4, 0); top7 = bits(im, 11, 5); end
      3'd3: begin op = 64'd35; rd = bits(im, 4, 0); top7 = bits(im, 11, 5); end
      3'd4: begin
        op = 64'd99;
        rd = bits(im, 4, 1) * 64'd2 + bits(im, 11, 11);
        top7 = bits(im, 12, 12) * 64'd64 + bits(im, 10, 5);
      end
      3'd5: begin
        op = 64'd111; upper = 1'b1;
        up20 = bits(im, 20, 20) * 64'd524288 + bits(im, 10, 1) * 64'd512
             + bits(im, 11, 11) * 64'd256 + bits(im, 19, 12);
      end
      3'd6: begin op = 64'd103; f3 = 64'd0; rs2 = bits(im, 4, 0); top7 = bits(im, 11, 5); end
      default: begin op = 64'd55; upper = 1'b1; up20 = bits(im, 31, 12); end
    endcase
    if (upper) w = op + rd * 64'd128 + up20 * 64'd4096;
    else w = op + rd * 64'd128 + f3 * 64'd4096 + rs1 * 64'd32768
           + rs2 * 64'd1048576 + top7 * 64'd33554432;
    return w[31:0];
  endfunction

  // Legality of the immediate from the class's numeric range rules.
  function automatic bit model_illegal(input bundle_t b);
    longint s;
    s = longint'($signed(b.imm));
    case (b.fmt)
      3'd1: begin
        if (b.f3 == 3'd1 || b.f3 == 3'd5) return (s < 0) || (s > 31);
        return (s < -2048) || (s > 2047);
      end
      3'd2, 3'd3, 3'd6: return (s < -2048) || (s > 2047);
      3'd4: return (s < -4096) || (s > 4094) || (s % 2 != 0);
      3'd5: return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      3'd7: return (b.imm & 32'hFFF) != 32'd0;
      default: return 1'b0;
    endcase
  endfunction

  // Independent decoder keyed on the opcode; returns {rd, rs1, rs2, imm}.
  function automatic logic [46:0] decode_rt(input logic [31:0] w);
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
    case (w[6:0])
      7'h33: begin rd = w[11:7]; rs1 = w[19:15]; rs2 = w[24:20]; end
      7'h13: begin
        rd = w[11:7]; rs1 = w[19:15];
        if (w[14:12] == 3'b001 || w[14:12] == 3'b101) imm = {27'd0, w[24:20]};
        else imm = {{20{w[31]}}, w[31:20]};
      end
      7'h03, 7'h67: begin rd = w[11:7]; rs1 = w[19:15]; imm = {{20{w[31]}}, w[31:20]}; end
      7'h23: begin rs1 = w[19:15]; rs2 = w[24:20]; imm = {{20{w[31]}}, w[31:25], w[11:7]}; end
      7'h63: begin
        rs1 = w[19:15]; rs2 = w[24:20];
        imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      7'h6F: begin rd = w[11:7]; imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
      7'h37: begin rd = w[11:7]; imm = {w[31:12], 12'd0}; end
      default: imm = 32'd0;
    endcase
    return {rd, rs1, rs2, imm};
  endfunction

  // Fields a class actually carries, as the decoder should recover them.
  function automatic logic [46:0] expect_rt(input bundle_t b);
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    rd  = (b.fmt == 3'd3 || b.fmt == 3'd4) ? 5'd0 : b.rd;
    rs1 = (b.fmt == 3'd5 || b.fmt == 3'd7) ? 5'd0 : b.rs1;
    rs2 = (b.fmt == 3'd0 || b.fmt == 3'd3 || b.fmt == 3'd4) ? b.rs2 : 5'd0;
    imm = (b.fmt == 3'd0) ? 32'd0 : b.imm;
    return {rd, rs1, rs2, imm};
  endfunction

  function automatic bundle_t mk(input int fmt, input int f3, input int f7, input int rd,
                                 input int rs1, input int rs2, input logic [31:0] imm);
    bundle_t b;
    b.fmt = 3'(fmt); b.f3 = 3'(f3); b.f7 = 7'(f7);
    b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2); b.imm = imm;
    return b;
  endfunction

  function automatic logic [31:0] rand_imm12();
    return 32'($urandom_range(0, 4095)) - 32'd2048;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           32'd0);
    case (b.fmt)
      3'd1: b.imm = (b.f3 == 3'd1 || b.f3 == 3'd5) ? 32'($urandom_range(0, 31)) : rand_imm12();
      3'd2, 3'd3, 3'd6: b.imm = rand_imm12();
      3'd4: b.imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
      3'd5: b.imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
      3'd7: b.imm = $urandom & 32'hFFFFF000;
      default: b.imm = $urandom;
    endcase
    return b;
  endfunction

  // Drive one bundle and hold it until accepted (bounded wait).
  task automatic push(input bundle_t b, input bit rnd);
    bit done;
    done = 1'b0;
    cur = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    check("push_accepted", 64'(done), 64'd1);
  endtask

  // Scoreboard compare on every falling edge, then model push/pop for the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      check("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
      if (sb.size() == 0) begin
        check("idle_zero", 64'({out_err, out_instr}), 64'd0);
      end else begin
        hd = sb[0];
        check("word", 64'(out_instr), 64'(model_word(hd)));
        check("err", 64'(out_err), 64'(model_illegal(hd) & CHECK_EN));
        if (!model_illegal(hd)) check("roundtrip", 64'(decode_rt(out_instr)), 64'(expect_rt(hd)));
      end
      pushing = in_valid && (sb.size() != DEPTH);
      if (out_ready && sb.size() != 0) void'(sb.pop_front());
      if (pushing) sb.push_back(cur);
    end
  end

  initial begin
    int t0;
    cur = mk(0, 0, 0, 0, 0, 0, 32'd0);
    //            fmt f3 f7    rd rs1 rs2 imm                word              illegal
    vb[0]  = mk(0, 0, 0,    3, 1, 2, 32'd0);        vw[0]  = 32'h002081B3; vi[0]  = 1'b0;
    vb[1]  = mk(1, 0, 'h55, 1, 0, 7, 32'hFFFFFFFF); vw[1]  = 32'hFFF00093; vi[1]  = 1'b0;
    vb[2]  = mk(3, 2, 0,    5, 1, 2, 32'd8);        vw[2]  = 32'h0020A423; vi[2]  = 1'b0;
    vb[3]  = mk(5, 3, 'h7F, 1, 3, 4, 32'd8);        vw[3]  = 32'h008000EF; vi[3]  = 1'b0;
    vb[4]  = mk(7, 0, 0,    5, 9, 0, 32'h12345000); vw[4]  = 32'h123452B7; vi[4]  = 1'b0;
    vb[5]  = mk(7, 0, 0,    5, 9, 0, 32'h12345001); vw[5]  = 32'h123452B7; vi[5]  = 1'b1;
    vb[6]  = mk(4, 0, 0,    1, 0, 0, 32'd3);        vw[6]  = 32'h00000163; vi[6]  = 1'b1;
    vb[7]  = mk(1, 5, 'h20, 1, 2, 0, 32'd3);        vw[7]  = 32'h40315093; vi[7]  = 1'b0;
    vb[8]  = mk(6, 7, 0,    1, 2, 5, 32'd4);        vw[8]  = 32'h004100E7; vi[8]  = 1'b0;
    vb[9]  = mk(4, 0, 0,    0, 1, 2, 32'hFFFFFFFC); vw[9]  = 32'hFE208EE3; vi[9]  = 1'b0;
    vb[10] = mk(1, 0, 0,    1, 0, 0, 32'd2048);     vw[10] = 32'h80000093; vi[10] = 1'b1;
    vb[11] = mk(1, 1, 0,    1, 2, 0, 32'd32);       vw[11] = 32'h00011093; vi[11] = 1'b1;
    vb[12] = mk(5, 0, 0,    1, 0, 0, 32'd9);        vw[12] = 32'h008000EF; vi[12] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Directed vectors: pin the model to literals, then one-cycle latency on the DUT.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      check($sformatf("model_word_%0d", i), 64'(model_word(vb[i])), 64'(vw[i]));
      check($sformatf("model_ill_%0d", i), 64'(model_illegal(vb[i])), 64'(vi[i]));
      push(vb[i], 1'b0);
      @(negedge clk);
      check($sformatf("lat_valid_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("lat_instr_%0d", i), 64'(out_instr), 64'(vw[i]));
      check($sformatf("lat_err_%0d", i), 64'(out_err), 64'(vi[i] & CHECK_EN));
      @(posedge clk);
      #1;
    end

    // Backpressure: fill, hold a third bundle, then release in order.
    out_ready = 1'b0;
    push(vb[0], 1'b0);
    push(vb[1], 1'b0);
    @(negedge clk);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    cur = vb[2];
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_held_ready", 64'(in_ready), 64'd0);
      check("bp_held_head", 64'(out_instr), 64'(vw[0]));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(vb[2], 1'b0);

    // Streaming push+pop keeps occupancy steady: one accept per cycle.
    t0 = cyc;
    for (int k = 3; k < 7; k++) push(vb[k], 1'b0);
    check("stream_cycles", 64'(cyc - t0), 64'd4);

    // Reset with two entries queued.
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    push(vb[3], 1'b0);
    push(vb[4], 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_instr", 64'(out_instr), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(vb[7], 1'b0);
    @(negedge clk);
    check("post_rst_first", 64'(out_instr), 64'(vw[7]));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_hold", 64'(out_instr), 64'(vw[7]));
    @(negedge clk);
    check("post_rst_alone", 64'(out_valid), 64'd0);

    // Random legal bundles with random consumer backpressure.
    for (int n = 0; n < 10000; n++) begin
      push(rand_bundle(), 1'b1);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("drained", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
